// File: rtl/opb_arb_pkg.sv
// Shared types and helpers for the round-robin OPB bus arbiter.
package opb_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, ACTIVE} arb_state_t;

  localparam int MAX_MASTERS = 8;
  localparam int TOUT_CNT_W  = 8;

  // OR-encode so a one-hot input needs no priority chain.
  function automatic logic [2:0] onehot2idx(input logic [MAX_MASTERS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/opb_rr_bus_arbiter_if.sv
// OPB arbitration signal bundle: master-side requests/selects, slave acks, arbiter grants.
interface opb_rr_bus_arbiter_if #(parameter int C_NUM_MASTERS = 4);
  logic [C_NUM_MASTERS-1:0] M_request;
  logic [C_NUM_MASTERS-1:0] M_busLock;
  logic [C_NUM_MASTERS-1:0] M_select;
  logic                     Sl_xferAck;
  logic                     Sl_retry;
  logic                     Sl_errAck;
  logic                     Sl_toutSup;
  logic [C_NUM_MASTERS-1:0] OPB_MGrant;
  logic                     OPB_timeout;
  logic                     arb_busy;
  logic [2:0]               grant_id;

  // Arbiter view.
  modport slave (
    input  M_request, M_busLock, M_select, Sl_xferAck, Sl_retry, Sl_errAck, Sl_toutSup,
    output OPB_MGrant, OPB_timeout, arb_busy, grant_id
  );

  // Bus/master view.
  modport master (
    output M_request, M_busLock, M_select, Sl_xferAck, Sl_retry, Sl_errAck, Sl_toutSup,
    input  OPB_MGrant, OPB_timeout, arb_busy, grant_id
  );
endinterface

// File: rtl/opb_arb_rr_picker.sv
// Combinational round-robin pick: rotate requests so ptr is bit 0, take lowest set, rotate back.
module opb_arb_rr_picker #(
  parameter int N = 4
)(
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] pick,
  output logic         vld
);
  logic [N-1:0] rot, rot_pick;

  always_comb begin
    rot      = N'({req, req} >> ptr);
    rot_pick = rot & (~rot + 1'b1);
    pick     = N'({rot_pick, rot_pick} << ptr >> N);
    vld      = |req;
  end
endmodule

// File: rtl/opb_rr_bus_arbiter.sv
// Round-robin OPB master arbiter with bus lock and transfer timeout.
// Optional OPB_ARB_PARK_EN: idle grant parks on the last owner instead of dropping to zero.
module opb_rr_bus_arbiter
  import opb_arb_pkg::*;
#(
  parameter int C_NUM_MASTERS    = 4,
  parameter int C_TIMEOUT_CYCLES = 16
)(
  input logic                OPB_Clk,
  input logic                OPB_Rst,
  opb_rr_bus_arbiter_if.slave bus
);
  localparam int N = C_NUM_MASTERS;
`ifdef OPB_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  arb_state_t             state_q, state_d;
  logic [N-1:0]           grant_q, grant_d, pick;
  logic [2:0]             owner_q, owner_d, ptr_q, ptr_d, owner_nxt;
  logic [TOUT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   tout_q, tout_d, pick_vld, own_sel, own_lock, ack;

  opb_arb_rr_picker #(.N(N)) u_picker (
    .req  (bus.M_request),
    .ptr  (ptr_q),
    .pick (pick),
    .vld  (pick_vld)
  );

  // The grant register is the owner mask, so non-owner select/lock fall out naturally.
  assign own_sel   = |(bus.M_select  & grant_q);
  assign own_lock  = |(bus.M_busLock & grant_q);
  assign ack       = bus.Sl_xferAck | bus.Sl_retry | bus.Sl_errAck;
  assign owner_nxt = (owner_q == 3'(N-1)) ? 3'd0 : owner_q + 3'd1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          owner_d = onehot2idx(MAX_MASTERS'(pick));
          state_d = GRANT;
        end else if (PARK && own_sel) begin
          cnt_d   = '0;
          state_d = ACTIVE;
        end else if (PARK) begin
          grant_d = {{(N-1){1'b0}}, 1'b1} << owner_q;
        end else begin
          grant_d = '0;
        end
      end
      GRANT: begin
        if (own_sel) begin
          cnt_d   = '0;
          state_d = ACTIVE;
        end else begin
          if (!PARK) grant_d = '0;
          ptr_d   = owner_nxt;
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (!own_sel) begin
          if (own_lock) begin
            state_d = GRANT;
          end else begin
            if (!PARK) grant_d = '0;
            ptr_d   = owner_nxt;
            state_d = IDLE;
          end
        end else if (ack) begin
          cnt_d = '0;
        end else if (!bus.Sl_toutSup) begin
          if (cnt_q == TOUT_CNT_W'(C_TIMEOUT_CYCLES - 1)) begin
            tout_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.OPB_MGrant  = grant_q;
  assign bus.OPB_timeout = tout_q;
  assign bus.arb_busy    = (state_q != IDLE);
  assign bus.grant_id    = owner_q;
endmodule

// File: tb/tb_opb_rr_bus_arbiter.sv
// Directed + randomized bench for opb_rr_bus_arbiter against a round-robin/timeout reference model.
module tb_opb_rr_bus_arbiter;
  localparam int N = 4;
  localparam int T = 16;
`ifdef OPB_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;
  int   m_ptr   = 0;

  opb_rr_bus_arbiter_if #(.C_NUM_MASTERS(N)) bus ();

  opb_rr_bus_arbiter #(.C_NUM_MASTERS(N), .C_TIMEOUT_CYCLES(T)) dut (
    .OPB_Clk (clk),
    .OPB_Rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  // Reference: first requester found walking upward from the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] idle_grant(input int last);
    return PARK ? oh(last) : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.M_request  = '0;
    bus.M_busLock  = '0;
    bus.M_select   = '0;
    bus.Sl_xferAck = 1'b0;
    bus.Sl_retry   = 1'b0;
    bus.Sl_errAck  = 1'b0;
    bus.Sl_toutSup = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    chk("rst_grant", bus.OPB_MGrant, 0);
    chk("rst_tout",  bus.OPB_timeout, 0);
    chk("rst_busy",  bus.arb_busy, 0);
    chk("rst_id",    bus.grant_id, 0);
    tick();
    rst   = 1'b0;
    m_ptr = 0;
  endtask

  // One arbitration round from an idle bus: grant, optional select burst, release.
  task automatic serve_one(input logic [N-1:0] req, input int len, input bit abandon);
    int w;
    bus.M_request = req;
    tick();
    w = rr_pick(req, m_ptr);
    chk("grant",    bus.OPB_MGrant, oh(w));
    chk("grant_id", bus.grant_id, w);
    chk("busy",     bus.arb_busy, 1);
    if (!abandon) begin
      bus.M_select = oh(w);
      for (int c = 0; c < len; c++) begin
        bus.Sl_xferAck = 1'($urandom_range(0, 1));
        tick();
        chk("grant_hold", bus.OPB_MGrant, oh(w));
      end
      bus.M_select   = '0;
      bus.Sl_xferAck = 1'b0;
    end
    tick();
    chk("grant_drop", bus.OPB_MGrant, idle_grant(w));
    chk("busy_drop",  bus.arb_busy, 0);
    chk("no_tout",    bus.OPB_timeout, 0);
    m_ptr = (w + 1) % N;
  endtask

  // mode 0: no ack, 1: timeout suppressed, 2: ack on the terminal cycle.
  task automatic tout_run(input int mode);
    int   run;
    logic expv;
    do_reset();
    bus.M_request = 4'b0001;
    tick();
    bus.M_request  = '0;
    bus.M_select   = 4'b0001;
    bus.Sl_toutSup = (mode == 1);
    tick();
    run = 0;
    for (int k = 1; k <= 20; k++) begin
      bus.Sl_xferAck = (mode == 2 && k == T);
      if (bus.Sl_xferAck) begin
        run = 0; expv = 1'b0;
      end else if (bus.Sl_toutSup) begin
        expv = 1'b0;
      end else begin
        run++;
        expv = (run == T);
        if (run == T) run = 0;
      end
      tick();
      chk($sformatf("tout_m%0d_k%0d", mode, k), bus.OPB_timeout, expv);
    end
    clear_inputs();
    tick();
    chk("tout_drop", bus.OPB_MGrant, idle_grant(0));
  endtask

  initial begin
    int w;
    clear_inputs();
    #2;

    // Single request, then pointer continues after the owner.
    do_reset();
    serve_one(4'b0100, 1, 1'b0);
    serve_one(4'b1011, 1, 1'b0);

    // All masters requesting: strict rotation with idle gaps.
    do_reset();
    for (int i = 0; i < 5; i++) serve_one(4'b1111, 1, 1'b0);

    // Bus lock keeps master 1 across two selects while master 2 waits.
    do_reset();
    bus.M_request = 4'b0110;
    tick();
    w = rr_pick(bus.M_request, m_ptr);
    chk("lock_grant", bus.OPB_MGrant, oh(w));
    bus.M_select  = oh(w);
    bus.M_busLock = oh(w);
    tick();
    chk("lock_act", bus.OPB_MGrant, oh(w));
    bus.M_select = bus.M_request & ~oh(w);
    tick();
    chk("lock_held", bus.OPB_MGrant, oh(w));
    chk("lock_busy", bus.arb_busy, 1);
    bus.M_select = oh(w);
    tick();
    chk("lock_sel2", bus.OPB_MGrant, oh(w));
    bus.M_select  = '0;
    bus.M_busLock = '0;
    tick();
    chk("lock_drop", bus.OPB_MGrant, idle_grant(w));
    m_ptr = (w + 1) % N;
    serve_one(4'b0110, 1, 1'b0);

    // Timeout behaviour.
    tout_run(0);
    tout_run(1);
    tout_run(2);

    // Abandoned grant forfeits the turn.
    do_reset();
    serve_one(4'b0011, 0, 1'b1);
    serve_one(4'b0011, 1, 1'b0);

    // Asynchronous reset in the middle of a transfer.
    do_reset();
    bus.M_request = 4'b0001;
    tick();
    bus.M_select = 4'b0001;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_grant", bus.OPB_MGrant, 0);
    chk("async_busy",  bus.arb_busy, 0);
    tick();
    rst = 1'b0;
    clear_inputs();
    m_ptr = 0;
    serve_one(4'b1111, 1, 1'b0);

`ifdef OPB_ARB_PARK_EN
    do_reset();
    tick();
    chk("park0_grant", bus.OPB_MGrant, 4'b0001);
    chk("park0_busy",  bus.arb_busy, 0);
    bus.M_select = 4'b0001;
    tick();
    chk("park_sel_busy",  bus.arb_busy, 1);
    chk("park_sel_grant", bus.OPB_MGrant, 4'b0001);
    bus.M_select = '0;
    tick();
    chk("park_rel_busy",  bus.arb_busy, 0);
    chk("park_rel_grant", bus.OPB_MGrant, 4'b0001);
    m_ptr = 1;
    serve_one(4'b0011, 1, 1'b0);
`endif

    // Randomized rounds against the round-robin model.
    do_reset();
    for (int i = 0; i < 40; i++)
      serve_one(N'($urandom_range(1, 15)), $urandom_range(1, 3), ($urandom_range(0, 3) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
